mem_port_arbiter: RTL

//  Shares the single-port 512x32 program/data RAM between two requesters.
//  - Port C: the CPU control unit (fetch, ld, st).
//  - Port L: the program loader/debug port (preload, inspect memory).

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 22 ++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the RAM port arbiter.
// Holds the FSM encoding, port identifiers and the latency counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_L = 1'b1;

    localparam int CNT_W = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker.
// req[0] is port C, req[1] is port L; ties go to the port that did not win last.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_winner,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = PORT_C;
        if (req == 2'b11) begin
            winner = ~last_winner;
        end else if (req[1]) begin
            winner = PORT_L;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port 512x32 RAM between the CPU control unit (C)
// and the loader/debug port (L), one transaction in flight at a time.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    output logic                  c_ack,
    output logic [DATA_WIDTH-1:0] c_rdata,
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic [ADDR_WIDTH-1:0] l_addr,
    input  logic [DATA_WIDTH-1:0] l_wdata,
    output logic                  l_ack,
    output logic [DATA_WIDTH-1:0] l_rdata,
    output logic                  Mem_Read,
    output logic                  Mem_Write,
    output logic                  Mem_enable512x32,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  grant_id
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  grant_id_q, grant_id_d;
    logic                  last_winner_q, last_winner_d;
    logic [DATA_WIDTH-1:0] c_rdata_q, c_rdata_d;
    logic [DATA_WIDTH-1:0] l_rdata_q, l_rdata_d;
    logic                  capture;
    logic                  arb_winner;
    logic                  arb_valid;
    logic                  issue;

    rr_arb2 u_rr_arb2 (
        .req         ({l_req, c_req}),
        .last_winner (last_winner_q),
        .winner      (arb_winner),
        .valid       (arb_valid)
    );

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        grant_id_d    = grant_id_q;
        last_winner_d = last_winner_q;
        capture       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d       = ST_ISSUE;
                    grant_id_d    = arb_winner;
                    last_winner_d = arb_winner;
                    if (arb_winner == PORT_L) begin
                        we_d    = l_we;
                        addr_d  = l_addr;
                        wdata_d = l_wdata;
                    end else begin
                        we_d    = c_we;
                        addr_d  = c_addr;
                        wdata_d = c_wdata;
                    end
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = CNT_LOAD;
                    if (CNT_LOAD == '0) begin
                        state_d = ST_DONE;
                        capture = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                // Read data is valid on the edge where the count hits zero.
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                    capture = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        c_rdata_d = c_rdata_q;
        l_rdata_d = l_rdata_q;
        if (capture) begin
            if (grant_id_q == PORT_L) begin
                l_rdata_d = mem_rdata;
            end else begin
                c_rdata_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt_q         <= '0;
            grant_id_q    <= PORT_C;
            last_winner_q <= PORT_L;
            c_rdata_q     <= '0;
            l_rdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            grant_id_q    <= grant_id_d;
            last_winner_q <= last_winner_d;
            c_rdata_q     <= c_rdata_d;
            l_rdata_q     <= l_rdata_d;
        end
    end

    // Outputs decode straight from state so an async reset drops them at once.
    assign issue            = (state_q == ST_ISSUE);
    assign Mem_enable512x32 = issue;
    assign Mem_Read         = issue && !we_q;
    assign Mem_Write        = issue && we_q;
    assign mem_addr         = issue ? addr_q : '0;
    assign mem_wdata        = issue ? wdata_q : '0;
    assign c_ack            = (state_q == ST_DONE) && (grant_id_q == PORT_C);
    assign l_ack            = (state_q == ST_DONE) && (grant_id_q == PORT_L);
    assign busy             = (state_q != ST_IDLE);
    assign grant_id         = grant_id_q;
    assign c_rdata          = c_rdata_q;
    assign l_rdata          = l_rdata_q;

endmodule
